// File: rtl/pwm_deadtime_inserter_pkg.sv
// Shared definitions for the PWM dead-time inserter: state encoding, defaults
// and a small state-class helper.
package pwm_deadtime_inserter_pkg;

   localparam int DT_W_DEF     = 4;
   localparam int MIN_DEAD_DEF = 1;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_LS_ON   = 3'd1,
      ST_DT_RISE = 3'd2,
      ST_HS_ON   = 3'd3,
      ST_DT_FALL = 3'd4,
      ST_FAULT   = 3'd5
   } state_e;

   function automatic logic is_dead_state(input state_e s);
      return (s == ST_DT_RISE) || (s == ST_DT_FALL);
   endfunction

endpackage

// File: rtl/pwm_deadtime_inserter_dt_counter.sv
// Dead-band down-counter: loads the effective dead time, decrements while the
// band lasts and flags the last band cycle (count == 1).
module pwm_deadtime_inserter_dt_counter #(
   parameter int DT_W = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            load_i,
   input  logic            dec_i,
   input  logic [DT_W-1:0] load_val_i,
   output logic            expired_o
);

   logic [DT_W-1:0] cnt_q;
   logic [DT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == DT_W'(1));

endmodule

// File: rtl/pwm_deadtime_inserter.sv
// Converts a single-ended PWM into a complementary high/low-side gate pair with
// a programmable dead band, enable gating and a sticky fault shutdown.
//
//   state      | meaning
//   OFF        | both off, waiting for enable (no fault)
//   LS_ON      | low side driven
//   DT_RISE    | both off, dead band before high side
//   HS_ON      | high side driven
//   DT_FALL    | both off, dead band before low side
//   FAULT      | both off, fault latched until cleared
module pwm_deadtime_inserter
   import pwm_deadtime_inserter_pkg::*;
#(
   parameter int DT_W     = DT_W_DEF,
   parameter int MIN_DEAD = MIN_DEAD_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic            i_pwm,
   input  logic [DT_W-1:0] i_dead,
   input  logic            i_fault,
   input  logic            i_fault_clr,
   output logic            o_hs,
   output logic            o_ls,
   output logic            o_dead,
   output logic            o_fault
);

   localparam logic [DT_W-1:0] MIN_DEAD_V = DT_W'(MIN_DEAD);

   state_e          state_q;
   state_e          state_d;
   logic [DT_W-1:0] deff;
   logic            cnt_load;
   logic            cnt_dec;
   logic            cnt_exp;
   logic            hs_q;
   logic            ls_q;
   logic            dead_q;
   logic            fault_q;

   assign deff = (i_dead < MIN_DEAD_V) ? MIN_DEAD_V : i_dead;

   // A live fault outranks the sticky-fault hold, which in turn outranks disable.
   always_comb begin
      state_d = state_q;
      if (i_fault) begin
         state_d = ST_FAULT;
      end else if (state_q == ST_FAULT) begin
         if (i_fault_clr) begin
            state_d = ST_OFF;
         end
      end else if (!i_en) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF:     state_d = i_pwm ? ST_DT_RISE : ST_DT_FALL;
            ST_LS_ON:   if (i_pwm) state_d = ST_DT_RISE;
            ST_DT_RISE: begin
               if (!i_pwm) begin
                  state_d = ST_LS_ON;
               end else if (cnt_exp) begin
                  state_d = ST_HS_ON;
               end
            end
            ST_HS_ON:   if (!i_pwm) state_d = ST_DT_FALL;
            ST_DT_FALL: begin
               if (i_pwm) begin
                  state_d = ST_HS_ON;
               end else if (cnt_exp) begin
                  state_d = ST_LS_ON;
               end
            end
            default:    state_d = ST_OFF;
         endcase
      end
   end

   // No direct DT_RISE<->DT_FALL path exists, so any change into a band is an entry.
   assign cnt_load = is_dead_state(state_d) && !is_dead_state(state_q);
   assign cnt_dec  = is_dead_state(state_d) && (state_d == state_q);

   pwm_deadtime_inserter_dt_counter #(
      .DT_W (DT_W)
   ) u_dt_counter (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (deff),
      .expired_o  (cnt_exp)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_OFF;
         hs_q    <= 1'b0;
         ls_q    <= 1'b0;
         dead_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hs_q    <= (state_d == ST_HS_ON);
         ls_q    <= (state_d == ST_LS_ON);
         dead_q  <= is_dead_state(state_d);
         fault_q <= (state_d == ST_FAULT);
      end
   end

   assign o_hs    = hs_q;
   assign o_ls    = ls_q;
   assign o_dead  = dead_q;
   assign o_fault = fault_q;

endmodule
